// File: rtl/decode_wb_regfile.sv
// Y86-style decode stage with register-file writeback, operand reads and a debug port.
// Define DECODE_BYPASS_EN to forward same-cycle writeback data onto valA/valB.
module decode_wb_regfile #(
  parameter int DATA_W = 64,
  parameter int NREG   = 15,
  parameter int RSP_ID = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        icode,
  input  logic [3:0]        rA,
  input  logic [3:0]        rB,
  input  logic              cnd,
  input  logic              wb_en,
  input  logic [3:0]        w_dstE,
  input  logic [3:0]        w_dstM,
  input  logic [DATA_W-1:0] w_valE,
  input  logic [DATA_W-1:0] w_valM,
  output logic [3:0]        srcA,
  output logic [3:0]        srcB,
  output logic [3:0]        dstE,
  output logic [3:0]        dstM,
  output logic [DATA_W-1:0] valA,
  output logic [DATA_W-1:0] valB,
  input  logic [3:0]        dbg_idx,
  output logic [DATA_W-1:0] dbg_data
);

  localparam logic [3:0] NONE    = 4'hF;
  localparam logic [3:0] RSP     = 4'(RSP_ID);
  localparam logic [3:0] NREG_ID = 4'(NREG);

  logic [DATA_W-1:0] regs [NREG];

  always_comb begin
    srcA = NONE;
    srcB = NONE;
    dstE = NONE;
    dstM = NONE;
    case (icode)
      4'h2: begin
        srcA = rA;
        dstE = cnd ? rB : NONE;
      end
      4'h3: dstE = rB;
      4'h4: begin
        srcA = rA;
        srcB = rB;
      end
      4'h5: begin
        srcB = rB;
        dstM = rA;
      end
      4'h6: begin
        srcA = rA;
        srcB = rB;
        dstE = rB;
      end
      4'h8: begin
        srcB = RSP;
        dstE = RSP;
      end
      4'h9: begin
        srcA = RSP;
        srcB = RSP;
        dstE = RSP;
      end
      4'hA: begin
        srcA = rA;
        srcB = RSP;
        dstE = RSP;
      end
      4'hB: begin
        srcA = RSP;
        srcB = RSP;
        dstE = RSP;
        dstM = rA;
      end
      default: ;
    endcase
  end

  // IDs at or above NREG (including 0xF) never match an index, so they
  // read as zero and writes to them fall away.
  function automatic logic [DATA_W-1:0] rd(input logic [3:0] id);
    logic [DATA_W-1:0] r;
    r = '0;
    for (int i = 0; i < NREG; i++)
      if (id == 4'(i)) r = regs[i];
    return r;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (wb_en) begin
      for (int i = 0; i < NREG; i++) begin
        if (w_dstM == 4'(i))      regs[i] <= w_valM;
        else if (w_dstE == 4'(i)) regs[i] <= w_valE;
      end
    end
  end

`ifdef DECODE_BYPASS_EN
  // Forwarding is suppressed during reset so operands read zero.
  function automatic logic [DATA_W-1:0] fwd(input logic [3:0] id);
    logic [DATA_W-1:0] r;
    r = rd(id);
    if (rst_n && wb_en) begin
      if (id == w_dstM && w_dstM < NREG_ID)      r = w_valM;
      else if (id == w_dstE && w_dstE < NREG_ID) r = w_valE;
    end
    return r;
  endfunction

  always_comb begin
    valA = fwd(srcA);
    valB = fwd(srcB);
  end
`else
  always_comb begin
    valA = rd(srcA);
    valB = rd(srcB);
  end
`endif

  always_comb dbg_data = rd(dbg_idx);

endmodule

// File: tb/tb_decode_wb_regfile.sv
// Scoreboard bench for decode_wb_regfile: stimulus queues expected values, a
// negedge monitor pops and compares them against the live outputs.
module tb_decode_wb_regfile;

  localparam int DATA_W = 64;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [3:0]        icode, rA, rB;
  logic              cnd, wb_en;
  logic [3:0]        w_dstE, w_dstM;
  logic [DATA_W-1:0] w_valE, w_valM;
  logic [3:0]        srcA, srcB, dstE, dstM;
  logic [DATA_W-1:0] valA, valB;
  logic [3:0]        dbg_idx;
  logic [DATA_W-1:0] dbg_data;

  decode_wb_regfile #(.DATA_W(DATA_W), .NREG(15), .RSP_ID(4)) dut (
    .clk(clk), .rst_n(rst_n), .icode(icode), .rA(rA), .rB(rB), .cnd(cnd),
    .wb_en(wb_en), .w_dstE(w_dstE), .w_dstM(w_dstM), .w_valE(w_valE),
    .w_valM(w_valM), .srcA(srcA), .srcB(srcB), .dstE(dstE), .dstM(dstM),
    .valA(valA), .valB(valB), .dbg_idx(dbg_idx), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  typedef enum int {S_SRCA, S_SRCB, S_DSTE, S_DSTM, S_VALA, S_VALB, S_DBG} sel_t;
  typedef struct {
    sel_t              sel;
    string             name;
    logic [DATA_W-1:0] exp;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  task automatic push_exp(input sel_t sel, input string name, input logic [DATA_W-1:0] exp);
    exp_t e;
    e.sel = sel;
    e.name = name;
    e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic checkOutput(input exp_t e);
    logic [DATA_W-1:0] act;
    case (e.sel)
      S_SRCA:  act = {{(DATA_W-4){1'b0}}, srcA};
      S_SRCB:  act = {{(DATA_W-4){1'b0}}, srcB};
      S_DSTE:  act = {{(DATA_W-4){1'b0}}, dstE};
      S_DSTM:  act = {{(DATA_W-4){1'b0}}, dstM};
      S_VALA:  act = valA;
      S_VALB:  act = valB;
      default: act = dbg_data;
    endcase
    vectors++;
    if (act !== e.exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", e.name, act, e.exp);
    end
  endtask

  // Monitor: drain every expectation queued during the current cycle.
  always @(negedge clk) begin
    while (sb.size() > 0) checkOutput(sb.pop_front());
  end

  task automatic applyStimulus(input logic [3:0] ic, input logic [3:0] a,
                               input logic [3:0] b, input logic c);
    icode = ic;
    rA    = a;
    rB    = b;
    cnd   = c;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    wb_en = 1'b0;
    w_dstE = 4'hF; w_dstM = 4'hF; w_valE = '0; w_valM = '0;
    dbg_idx = 4'h0;
    applyStimulus(4'h0, 4'h0, 4'h0, 1'b0);
    repeat (2) @(posedge clk);
    #1;

    // Reset: decode still follows inputs, data reads zero
    applyStimulus(4'h6, 4'h1, 4'h8, 1'b0);
    push_exp(S_SRCA, "rst_srcA", 1);
    push_exp(S_DSTE, "rst_dstE", 8);
    push_exp(S_VALA, "rst_valA", 0);
    push_exp(S_DBG,  "rst_dbg0", 0);
    step();
    rst_n = 1'b1;

    // Fill R[i] = i, checking the pre-edge value is visible during the write
    for (int i = 0; i < 15; i++) begin
      wb_en = 1'b1;
      w_dstE = 4'(i);
      w_valE = DATA_W'(i);
      dbg_idx = 4'(i);
      push_exp(S_DBG, $sformatf("pre_write_r%0d", i), 0);
      step();
    end
    wb_en = 1'b0;
    w_dstE = 4'hF;
    for (int i = 0; i < 16; i++) begin
      dbg_idx = 4'(i);
      push_exp(S_DBG, $sformatf("fill_r%0d", i), (i == 15) ? 0 : DATA_W'(i));
      step();
    end

    // OPq rA=1 rB=8
    applyStimulus(4'h6, 4'h1, 4'h8, 1'b0);
    push_exp(S_SRCA, "op_srcA", 1);
    push_exp(S_SRCB, "op_srcB", 8);
    push_exp(S_DSTE, "op_dstE", 8);
    push_exp(S_DSTM, "op_dstM", 4'hF);
    push_exp(S_VALA, "op_valA", 1);
    push_exp(S_VALB, "op_valB", 8);
    step();

    // popq rA=3 with E/M collision on R4: valM must win
    applyStimulus(4'hB, 4'h3, 4'h0, 1'b0);
    wb_en = 1'b1;
    w_dstE = 4'h4; w_valE = 64'h10;
    w_dstM = 4'h4; w_valM = 64'h99;
    push_exp(S_SRCA, "pop_srcA", 4);
    push_exp(S_SRCB, "pop_srcB", 4);
    push_exp(S_DSTE, "pop_dstE", 4);
    push_exp(S_DSTM, "pop_dstM", 3);
`ifdef DECODE_BYPASS_EN
    push_exp(S_VALA, "pop_valA_same", 64'h99);
`else
    push_exp(S_VALA, "pop_valA_same", 4);
`endif
    step();
    wb_en = 1'b0;
    w_dstE = 4'hF; w_dstM = 4'hF;
    dbg_idx = 4'h4;
    push_exp(S_DBG,  "pop_r4", 64'h99);
    push_exp(S_VALA, "pop_valA_next", 64'h99);
    step();

    // cmovXX: dstE depends on cnd
    applyStimulus(4'h2, 4'h2, 4'h5, 1'b0);
    push_exp(S_DSTE, "cmov_nc_dstE", 4'hF);
    push_exp(S_SRCA, "cmov_srcA", 2);
    push_exp(S_SRCB, "cmov_srcB", 4'hF);
    push_exp(S_VALA, "cmov_valA", 2);
    step();
    cnd = 1'b1;
    push_exp(S_DSTE, "cmov_c_dstE", 5);
    step();

    // halt/nop: no registers involved
    applyStimulus(4'h0, 4'h3, 4'h3, 1'b1);
    push_exp(S_SRCA, "nop_srcA", 4'hF);
    push_exp(S_DSTE, "nop_dstE", 4'hF);
    push_exp(S_VALB, "nop_valB", 0);
    step();

    // mrmovq: full-width write via dstM, dropped write to ID 0xF
    applyStimulus(4'h5, 4'h0, 4'hE, 1'b0);
    wb_en = 1'b1;
    w_dstM = 4'h0; w_valM = 64'hDEAD_BEEF_0123_4567;
    w_dstE = 4'hF; w_valE = 64'hDEAD;
    push_exp(S_SRCA, "mr_srcA", 4'hF);
    push_exp(S_SRCB, "mr_srcB", 14);
    push_exp(S_DSTM, "mr_dstM", 0);
    push_exp(S_VALA, "mr_valA", 0);
    push_exp(S_VALB, "mr_valB", 14);
    step();
    wb_en = 1'b0;
    w_dstM = 4'hF;
    dbg_idx = 4'h0;
    push_exp(S_DBG, "mr_r0", 64'hDEAD_BEEF_0123_4567);
    step();
    dbg_idx = 4'hF;
    push_exp(S_DBG, "mr_rF", 0);
    step();

    // pushq rA=7 while R7 is written: same-cycle read depends on bypass
    applyStimulus(4'hA, 4'h7, 4'h0, 1'b0);
    wb_en = 1'b1;
    w_dstE = 4'h7; w_valE = 64'h55;
    push_exp(S_SRCA, "push_srcA", 7);
    push_exp(S_SRCB, "push_srcB", 4);
    push_exp(S_VALB, "push_valB", 64'h99);
`ifdef DECODE_BYPASS_EN
    push_exp(S_VALA, "push_valA_same", 64'h55);
`else
    push_exp(S_VALA, "push_valA_same", 7);
`endif
    step();
    wb_en = 1'b0;
    w_dstE = 4'hF;
    push_exp(S_VALA, "push_valA_next", 64'h55);
    step();

    // Mid-cycle reset with a pending write
    wb_en = 1'b1;
    w_dstE = 4'h3; w_valE = 64'h77;
    #2;
    rst_n = 1'b0;
    dbg_idx = 4'h7;
    #1;
    push_exp(S_DBG,  "mrst_r7", 0);
    push_exp(S_VALA, "mrst_valA", 0);
    push_exp(S_VALB, "mrst_valB", 0);
    push_exp(S_SRCA, "mrst_srcA", 7);
    step();
    dbg_idx = 4'h3;
    push_exp(S_DBG, "mrst_r3_held", 0);
    rst_n = 1'b1;
    wb_en = 1'b0;
    step();
    push_exp(S_DBG, "mrst_r3_after", 0);
    wb_en = 1'b1;
    step();
    wb_en = 1'b0;
    w_dstE = 4'hF;
    push_exp(S_DBG, "post_rst_write_r3", 64'h77);
    step();

    // Let the monitor drain; a stuck queue is itself a failure
    for (int k = 0; k < 10 && sb.size() > 0; k++) @(negedge clk);
    #1;
    if (sb.size() > 0) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL drain: got %0d pending, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/decode_wb_regfile.md
DECODE_WB_REGFILE -- requirements
Module: decode_wb_regfile

Interface
REQ-001 SHALL provide parameter DATA_W, default 64, register and data width in bits.
REQ-002 SHALL provide parameter NREG, default 15, number of implemented registers (legal range 2..15; IDs NREG..14 read 0 and ignore writes).
REQ-003 SHALL provide parameter RSP_ID, default 4, register ID used as stack pointer.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-006 SHALL have port icode  input  4  instruction code of the instruction being decoded.
REQ-007 SHALL have ports rA, rB  input  4 each  register specifier fields.
REQ-008 SHALL have port cnd  input  1  condition flag for conditional move (icode 2).
REQ-009 SHALL have port wb_en  input  1  writeback enable for the retiring instruction.
REQ-010 SHALL have ports w_dstE, w_dstM  input  4 each  writeback destination IDs (0xF = none).
REQ-011 SHALL have ports w_valE, w_valM  input  DATA_W each  writeback data.
REQ-012 SHALL have ports srcA, srcB, dstE, dstM  output  4 each  decoded register IDs (0xF = none).
REQ-013 SHALL have ports valA, valB  output  DATA_W each  operand read data.
REQ-014 SHALL have ports dbg_idx  input  4, dbg_data  output  DATA_W  debug read of any register.

Function
REQ-015 srcA SHALL be rA for icode 2,4,6,A; RSP_ID for icode 9,B; else 0xF.
REQ-016 srcB SHALL be rB for icode 4,5,6; RSP_ID for icode 8,9,A,B; else 0xF.
REQ-017 dstE SHALL be rB for icode 3,6, and for icode 2 only when cnd=1; RSP_ID for icode 8,9,A,B; else 0xF.
REQ-018 dstM SHALL be rA for icode 5,B; else 0xF.
REQ-019 ID decode SHALL be purely combinational, zero latency.
REQ-020 valA/valB/dbg_data SHALL be combinational reads of the register file; ID 0xF or any ID >= NREG SHALL read 0.
REQ-021 On rising clk with wb_en=1, register w_dstE SHALL load w_valE and register w_dstM SHALL load w_valM; wb_en=0 SHALL leave all registers unchanged.
REQ-022 Writes to ID 0xF or ID >= NREG SHALL be dropped without side effect.
REQ-023 When w_dstE == w_dstM (valid ID) with wb_en=1, w_valM SHALL win.
REQ-024 Without bypass, a read of a register being written in the same cycle SHALL return the pre-edge value; the new value SHALL be visible from the following cycle.
REQ-025 No arithmetic is performed; data SHALL pass unmodified at DATA_W bits.

Reset
REQ-026 rst_n low SHALL clear all NREG registers to 0 immediately, independent of clk.
REQ-027 During reset, valA, valB, dbg_data SHALL read 0; srcA/srcB/dstE/dstM SHALL still follow inputs.
REQ-028 A write coincident with a rst_n assertion SHALL be discarded; first write SHALL occur on the first rising clk after rst_n deasserts.

Configuration
REQ-029 Macro DECODE_BYPASS_EN SHALL control write-to-read forwarding.
REQ-030 With DECODE_BYPASS_EN defined: when wb_en=1 and srcA (or srcB) equals a valid w_dstM, valA (valB) SHALL equal w_valM; else if it equals a valid w_dstE, w_valE; else the register file value.
REQ-031 Without DECODE_BYPASS_EN: REQ-024 applies; no forwarding logic SHALL be present.

Verification
REQ-032 Reset, then write regs 0..14 with value=ID via w_dstE, one per cycle -> dbg_data reads ID for each idx; idx 0xF reads 0.
REQ-033 icode=6, rA=1, rB=8 after REQ-032 fill -> srcA=1, srcB=8, dstE=8, dstM=F, valA=1, valB=8.
REQ-034 icode=B, rA=3 -> srcA=4, srcB=4, dstE=4, dstM=3; wb_en=1, w_dstE=4, w_valE=0x10, w_dstM=4, w_valM=0x99 -> R4=0x99 next cycle.
REQ-035 icode=2, rA=2, rB=5, cnd=0 -> dstE=F; cnd=1 -> dstE=5.
REQ-036 icode=A, rA=7, w_dstE=7, w_valE=0x55, wb_en=1 -> valA=0x55 same cycle with DECODE_BYPASS_EN, valA=7 without; both =0x55 next cycle.
REQ-037 Assert rst_n low mid-run between edges -> all dbg_data reads 0 before next clk edge; write presented during reset not stored.
